// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 2-of-3 majority vote,
// parity/framing/break tags, first-word-fall-through receive FIFO.
// Ports: clk, rst (async, high), cfg_div (clk per tick - 1),
//   uart_rxd (serial in); str_tvalid/tdata/tuser/tready (stream,
//   tuser = {break, parity_err, framing_err}); sts_level, sts_ovf,
//   sts_clr (overrun flag clear).
module uart_rx_os #(
  parameter int    DW = 8,
  parameter string PT = "NONE",
  parameter int    SW = 1,
  parameter int    OS = 16,
  parameter int    CW = 16,
  parameter int    FD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       cfg_div,
  input  logic                uart_rxd,
  output logic                str_tvalid,
  output logic [DW-1:0]       str_tdata,
  output logic [2:0]          str_tuser,
  input  logic                str_tready,
  output logic [$clog2(FD):0] sts_level,
  output logic                sts_ovf,
  input  logic                sts_clr
);
  localparam int SCW = $clog2(OS);
  localparam int BW  = $clog2(DW + 1);
  localparam int AW  = $clog2(FD);
  localparam int WW  = DW + 3;
  localparam bit HAS_P = (PT != "NONE");
  localparam bit ODD_P = (PT == "ODD");
  localparam logic [SCW-1:0] S_A = SCW'(OS/2 - 1);
  localparam logic [SCW-1:0] S_B = SCW'(OS/2);
  localparam logic [SCW-1:0] S_C = SCW'(OS/2 + 1);
  localparam logic [SCW-1:0] S_E = SCW'(OS - 1);
  localparam logic [BW-1:0]  B_DL = BW'(DW - 1);
  localparam logic [BW-1:0]  B_SL = BW'(SW - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  logic       s1, rxs, rxs_q;
  logic [2:0] arm;
  logic       fall;

  // arm marks when rxs_q holds a real line sample, so a line
  // that is already low at reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
      arm   <= '0;
    end else begin
      s1    <= uart_rxd;
      rxs   <= s1;
      rxs_q <= rxs;
      arm   <= {arm[1:0], 1'b1};
    end
  end

  assign fall = arm[2] & rxs_q & ~rxs;

  state_t          state, state_n;
  logic [CW-1:0]   presc, presc_n;
  logic [SCW-1:0]  scnt, scnt_n;
  logic [1:0]      v, v_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic [DW-1:0]   sh, sh_n;
  logic            par, par_n;
  logic            perr, perr_n;
  logic            ferr, ferr_n;
  logic            brk, brk_n;
  logic            tick, vote, bit_end, maj;
  logic            push;
  logic [WW-1:0]   push_word;

  assign tick    = (presc == '0);
  assign vote    = tick & (scnt == S_C);
  assign bit_end = tick & (scnt == S_E);
  assign maj     = (v[0] & v[1]) | (v[0] & rxs) | (v[1] & rxs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      scnt  <= '0;
      v     <= '0;
      bcnt  <= '0;
      sh    <= '0;
      par   <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      brk   <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      scnt  <= scnt_n;
      v     <= v_n;
      bcnt  <= bcnt_n;
      sh    <= sh_n;
      par   <= par_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
      brk   <= brk_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = tick ? cfg_div : presc - 1'b1;
    scnt_n  = scnt;
    if (tick)
      scnt_n = (scnt == S_E) ? '0 : scnt + 1'b1;
    v_n = v;
    if (tick && scnt == S_A) v_n[0] = rxs;
    if (tick && scnt == S_B) v_n[1] = rxs;
    bcnt_n = bcnt;
    sh_n   = sh;
    par_n  = par;
    perr_n = perr;
    ferr_n = ferr;
    brk_n  = brk;
    push   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          presc_n = cfg_div;
          scnt_n  = '0;
          bcnt_n  = '0;
          par_n   = 1'b0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
          brk_n   = 1'b1;
        end
      end
      START: begin
        if (vote && maj) begin
          state_n = IDLE;
        end else if (bit_end) begin
          state_n = DATA;
          bcnt_n  = '0;
        end
      end
      DATA: begin
        if (vote) begin
          sh_n  = {maj, sh[DW-1:1]};
          par_n = par ^ maj;
          brk_n = brk & ~maj;
        end
        if (bit_end) begin
          bcnt_n = bcnt + 1'b1;
          if (bcnt == B_DL) begin
            bcnt_n  = '0;
            state_n = HAS_P ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (vote) begin
          perr_n = ((par ^ maj) != ODD_P);
          brk_n  = brk & ~maj;
        end
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (vote) begin
          ferr_n = ferr | ~maj;
          if (bcnt == '0) brk_n = brk & ~maj;
          // Leave mid-stop-bit so the next start edge is caught.
          if (bcnt == B_SL) begin
            push    = 1'b1;
            state_n = ferr_n ? WAIT_HIGH : IDLE;
          end
        end
        if (bit_end) bcnt_n = bcnt + 1'b1;
      end
      WAIT_HIGH: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign push_word = {brk_n, perr, ferr_n, sh};

  logic [WW-1:0] mem [FD];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, pop, wr;

  assign full = (cnt == (AW+1)'(FD));
  assign pop  = str_tvalid & str_tready;
  assign wr   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      sts_ovf <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      if (push & full & ~pop) sts_ovf <= 1'b1;
      else if (sts_clr)       sts_ovf <= 1'b0;
    end
  end

  assign str_tvalid             = (cnt != '0);
  assign {str_tuser, str_tdata} = mem[rp];
  assign sts_level              = cnt;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: vector table plus random frames against a
// frame-level model, for a no-parity and an even-parity receiver.
module tb_uart_rx_os;
  logic        clk, rst;
  logic [15:0] cfg_div;
  logic        line, sel;
  logic        rxd_a, rxd_b;
  logic        tvalid_a, tready_a, ovf_a, clr_a;
  logic        tvalid_b, tready_b, ovf_b, clr_b;
  logic [7:0]  tdata_a, tdata_b;
  logic [2:0]  tuser_a, tuser_b;
  logic [4:0]  level_a, level_b;

  assign rxd_a = sel ? 1'b1 : line;
  assign rxd_b = sel ? line : 1'b1;

  uart_rx_os #(.DW(8), .PT("NONE"), .SW(1), .OS(16),
               .CW(16), .FD(16)) u_a (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .uart_rxd(rxd_a),
    .str_tvalid(tvalid_a), .str_tdata(tdata_a),
    .str_tuser(tuser_a), .str_tready(tready_a),
    .sts_level(level_a), .sts_ovf(ovf_a), .sts_clr(clr_a));

  uart_rx_os #(.DW(8), .PT("EVEN"), .SW(1), .OS(16),
               .CW(16), .FD(16)) u_b (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .uart_rxd(rxd_b),
    .str_tvalid(tvalid_b), .str_tdata(tdata_b),
    .str_tuser(tuser_b), .str_tready(tready_b),
    .sts_level(level_b), .sts_ovf(ovf_b), .sts_clr(clr_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int rise_c;
  logic rnd = 1'b0;
  logic [10:0] qa[$], qb[$], ea[$], eb[$];

  always @(negedge clk) begin
    if (!rst && tvalid_a && tready_a) qa.push_back({tuser_a, tdata_a});
    if (!rst && tvalid_b && tready_b) qb.push_back({tuser_b, tdata_b});
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) begin
      tready_a = ($urandom_range(0, 3) != 0);
      tready_b = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic take(input logic s, input string nm,
                      input logic [10:0] w);
    logic [10:0] g;
    checks++;
    if ((s ? qb.size() : qa.size()) == 0) begin
      fails++;
      $display("FAIL %s: no beat, want %h", nm, w);
    end else begin
      g = s ? qb.pop_front() : qa.pop_front();
      if (g !== w) begin
        fails++;
        $display("FAIL %s: got %h want %h", nm, g, w);
      end
    end
  endtask

  // Frame-level expectation: tags follow from the bit values alone.
  function automatic logic [10:0] model(input logic s,
      input logic [7:0] d, input logic pb, input logic st);
    logic brk, pe, fe;
    fe  = ~st;
    pe  = s ? ((^d) ^ pb) : 1'b0;
    brk = (d == 8'h00) && (!s || !pb) && !st;
    return {brk, pe, fe, d};
  endfunction

  // Drives start, 8 data, optional parity, stop, then tail idle
  // bits; one line value per clk. gbit flips 3 clk mid-bit.
  task automatic send_frame(input logic s, input logic [7:0] d,
      input logic pb, input logic st, input int gbit,
      input int tail, input int stop_at);
    int bl, nb, n, idx;
    logic [11:0] bits;
    logic vb;
    bl = 16 * (int'(cfg_div) + 1);
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    nb = 9;
    if (s) begin
      bits[9] = pb;
      nb = 10;
    end
    bits[nb] = st;
    nb = nb + 1 + tail;
    n = (stop_at > 0) ? stop_at : nb * bl;
    sel = s;
    rise_c = -1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      idx = c / bl;
      vb = 1'b1;
      if (idx < 12) vb = bits[idx];
      if (gbit == idx && (c % bl) >= 35 && (c % bl) <= 37) vb = ~vb;
      line = vb;
      if (rise_c < 0 && (s ? tvalid_b : tvalid_a)) rise_c = c;
    end
  endtask

  typedef struct {
    logic        sel;
    logic [7:0]  data;
    logic        pbit;
    logic        stop;
    int          gbit;
    logic [10:0] ew;
  } vec_t;

  vec_t tv [8];
  logic s, pb, st;
  logic [7:0] d;
  int tl;

  initial begin
    tv[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, -1, 11'h0A5};
    tv[1] = '{1'b0, 8'h00, 1'b0, 1'b1,  4, 11'h000};
    tv[2] = '{1'b1, 8'h03, 1'b1, 1'b1, -1, 11'h203};
    tv[3] = '{1'b1, 8'h03, 1'b0, 1'b1, -1, 11'h003};
    tv[4] = '{1'b0, 8'h55, 1'b0, 1'b0, -1, 11'h155};
    tv[5] = '{1'b0, 8'h81, 1'b0, 1'b1, -1, 11'h081};
    tv[6] = '{1'b1, 8'h00, 1'b0, 1'b0, -1, 11'h500};
    tv[7] = '{1'b1, 8'h80, 1'b0, 1'b1, -1, 11'h280};

    rst = 1'b1; line = 1'b1; sel = 1'b0; cfg_div = 16'd3;
    tready_a = 1'b1; tready_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tvalid_a", tvalid_a, 0);
    chk("rst_level_a", level_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_tvalid_b", tvalid_b, 0);
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send_frame(tv[i].sel, tv[i].data, tv[i].pbit, tv[i].stop,
                 tv[i].gbit, 2, 0);
      if (i == 0) chk("tvalid_rise_clk", rise_c, 619);
      chk("vec_beats", tv[i].sel ? qb.size() : qa.size(), 1);
      take(tv[i].sel, "vec_word", tv[i].ew);
    end

    // False start: 20 clk low is shorter than the vote point.
    sel = 1'b0;
    line = 1'b0;
    repeat (20) @(posedge clk);
    #1 line = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("false_start_beats", qa.size(), 0);
    chk("false_start_level", level_a, 0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, -1, 1, 0);
    take(1'b0, "after_false_start", 11'h05A);

    // Held-low line for 3 frame times gives one break word.
    line = 1'b0;
    repeat (1920) @(posedge clk);
    #1 line = 1'b1;
    repeat (128) @(posedge clk);
    #1;
    chk("break_beats", qa.size(), 1);
    take(1'b0, "break_word", 11'h500);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1, -1, 1, 0);
    take(1'b0, "after_break", 11'h081);

    // Random frames on both receivers with a varying divisor.
    qa.delete(); qb.delete(); ea.delete(); eb.delete();
    rnd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i % 10 == 0) begin
        repeat (10) @(posedge clk);
        #1 cfg_div = 16'($urandom_range(0, 3));
      end
      s  = 1'($urandom);
      d  = 8'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      tl = $urandom_range(0, 2);
      if (!st && tl == 0) tl = 1;
      send_frame(s, d, pb, st, -1, tl, 0);
      if (s) eb.push_back(model(s, d, pb, st));
      else   ea.push_back(model(s, d, pb, st));
    end
    rnd = 1'b0;
    repeat (5) @(posedge clk);
    #1 tready_a = 1'b1;
    tready_b = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("rnd_beats_a", qa.size(), ea.size());
    chk("rnd_beats_b", qb.size(), eb.size());
    while (ea.size() > 0) take(1'b0, "rnd_word_a", ea.pop_front());
    while (eb.size() > 0) take(1'b1, "rnd_word_b", eb.pop_front());
    chk("rnd_ovf_a", ovf_a, 0);

    // Overrun: 18 frames into a 16-deep FIFO with no consumer.
    repeat (10) @(posedge clk);
    #1 cfg_div = 16'd1;
    qa.delete();
    tready_a = 1'b0;
    for (int k = 0; k < 18; k++)
      send_frame(1'b0, 8'(k), 1'b0, 1'b1, -1, 0, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("ovr_level", level_a, 16);
    chk("ovr_ovf", ovf_a, 1);
    tready_a = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("ovr_drain_beats", qa.size(), 16);
    for (int k = 0; k < 16; k++) take(1'b0, "ovr_word", 11'(k));
    chk("ovr_ovf_kept", ovf_a, 1);
    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    chk("ovr_clr", ovf_a, 0);

    // Reset mid-frame discards the partial frame and the FIFO.
    cfg_div = 16'd3;
    tready_a = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, -1, 1, 0);
    chk("pre_rst_level", level_a, 1);
    send_frame(1'b0, 8'h77, 1'b0, 1'b1, -1, 0, 5 * 64 + 32);
    rst = 1'b1;
    line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_tvalid", tvalid_a, 0);
    chk("mid_rst_level", level_a, 0);
    chk("mid_rst_ovf", ovf_a, 0);
    rst = 1'b0;
    tready_a = 1'b1;
    qa.delete();
    repeat (800) @(posedge clk);
    #1;
    chk("post_rst_beats", qa.size(), 0);
    chk("post_rst_level", level_a, 0);

    // Fastest divisor: 16 clk per bit.
    cfg_div = 16'd0;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, -1, 2, 0);
    chk("div0_beats", qa.size(), 1);
    take(1'b0, "div0_word", 11'h03C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver with runtime baud divisor, majority-vote bit sampling, parity/framing/break detection and a receive FIFO. It is the next-generation receive path of the UART peripheral. It converts the asynchronous `uart_rxd` line into a valid/ready byte stream and tags each word with its error status.

## Interface
- `DW`, 8: data bits per frame, 5..9.
- `PT`, "NONE": parity type, "NONE" / "EVEN" / "ODD".
- `SW`, 1: stop bits checked, 1 or 2.
- `OS`, 16: oversampling ticks per bit, even, >= 4.
- `CW`, 16: width of the baud divisor.
- `FD`, 16: FIFO depth in words, power of 2, >= 2.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_div` in CW: clk cycles per oversample tick minus 1. Bit period = OS*(cfg_div+1) clk. Changed only while the block is idle.
- `uart_rxd` in 1: serial input, idle high, asynchronous.
- `str_tvalid` out 1: FIFO not empty.
- `str_tdata` out DW: received data, LSB = first bit on the line.
- `str_tuser` out 3: {break, parity_err, framing_err}.
- `str_tready` in 1: consumer accept.
- `sts_level` out $clog2(FD)+1: FIFO occupancy.
- `sts_ovf` out 1: sticky overrun flag.
- `sts_clr` in 1: clears `sts_ovf`.

## Operation
- **Input synchroniser.** `uart_rxd` passes through a 2-flop synchroniser whose flops reset to 1. All logic uses the synchronised value `rxs`.
- **Prescaler.** Counts down from `cfg_div` to 0. It emits a one-clk `tick` at 0 and reloads. With `cfg_div=0`, `tick` asserts every clk.
- **Sample counter.** Counts ticks 0..OS-1 within a bit.
- **Majority vote.** `rxs` is sampled at ticks OS/2-1, OS/2 and OS/2+1. The bit value is the 2-of-3 majority, taken at tick OS/2+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE.** A falling edge on `rxs` reloads the prescaler, zeroes the sample counter, clears the error accumulators and enters START.
- **START.**
  - Majority 1: false start; return to IDLE with nothing pushed.
  - Majority 0: enter DATA at the end of the bit (tick OS-1).
- **DATA.** Shifts DW bits, LSB first, then goes to PARITY, or to STOP when PT="NONE".
- **PARITY.** `parity_err` = received parity bit differs from the expected value. EVEN: XOR of data and parity bit must be 0. ODD: the XOR must be 1.
- **STOP.**
  - Each stop bit is voted; any 0 sets `framing_err`.
  - At the vote of the last stop bit, the frame is pushed to the FIFO.
  - No framing error: go directly to IDLE, so the next start edge is accepted from mid-stop-bit.
  - Framing error: go to WAIT_HIGH.
- **Break.** `break` is set when all data bits, the parity bit (if present) and the first stop bit are 0. `framing_err` is also set in this case.
- **WAIT_HIGH.** Stays until `rxs`=1, then goes to IDLE. A held-low line therefore produces exactly one break word.
- **FIFO.**
  - First-word-fall-through, FD entries of DW+3 bits.
  - A push when full drops the frame and sets `sts_ovf`.
  - A pop happens on `str_tvalid & str_tready`.
  - Simultaneous push and pop while full is accepted; the level is unchanged.
  - Simultaneous push and pop while empty: push only, since `tvalid` was 0.
- **`sts_ovf` priority.** Set has priority over `sts_clr` in the same cycle.

## Timing
- **Reset values.**
  - `str_tvalid`=0, `sts_level`=0, `sts_ovf`=0.
  - FSM in IDLE; prescaler and sample counter at 0.
  - `str_tdata` and `str_tuser` are don't-care while `str_tvalid`=0.
- **Reset mid-frame.** Reset discards the partial frame and empties the FIFO. A line that is low when reset releases is not treated as a start edge.
- **Edge to START.** Falling edge on the `uart_rxd` pin to FSM in START: 3 clk (2 synchroniser stages plus 1 edge register).
- **Push to output.** `str_tvalid` rises 1 clk after the clk in which the last stop-bit vote occurs. `sts_level` updates in the same cycle.
- **Output stability.** `str_tdata` and `str_tuser` are registered and stable while `str_tvalid=1 & str_tready=0`.
- **Throughput.** Back-to-back frames with a single stop bit are received without loss, provided the consumer pops at least one word per frame time.

## Test plan
- **Basic frame.** DW=8, PT=NONE, OS=16, `cfg_div`=3 (64 clk/bit); send 0xA5 with 1 stop bit, `str_tready`=1 → one beat, `tdata`=0xA5, `tuser`=000, `tvalid` rising 1 clk after the stop-bit vote.
- **Glitch rejection.** `uart_rxd` low for 20 clk, then high → no beat, FSM back in IDLE, `sts_level`=0. Repeat with a single-sample glitch mid-DATA of 0x00 → `tdata`=0x00 (majority vote masks it).
- **Parity error.** PT=EVEN; send 0x03 with parity bit 1 → `tdata`=0x03, `tuser`=010. Send 0x03 with parity bit 0 → `tuser`=000.
- **Framing error and break.**
  - Send 0x55 with stop bit 0 → `tuser`=001.
  - Hold the line low for 3 frame times, then release → exactly one beat, `tdata`=0x00, `tuser`=101; the next valid frame 0x81 is received correctly.
- **Overrun.** FD=16, `str_tready`=0; send 18 frames 0x00..0x11 → `sts_level`=16, `sts_ovf`=1. Drain → 0x00..0x0F in order. Pulse `sts_clr` → `sts_ovf`=0.
- **Reset and divisor change.** Assert `rst` during DATA bit 4 → outputs at reset values, no beat. Then set `cfg_div`=0 (16 clk/bit) and send 0x3C → `tdata`=0x3C.
